// File: rtl/pwm_upd_sched_if.sv
// Bundle between the register block / counter and the PWM update scheduler.
// master = register block and counter side, slave = the scheduler.
interface pwm_upd_sched_if;
  // Commit control from the register block
  logic        upd_req;
  logic        upd_mode;
  logic        upd_abort;
  logic        clr_late;
  // Shadow values written over SPI
  logic [15:0] period_sh;
  logic [15:0] compare1_sh;
  logic [15:0] compare2_sh;
  logic [7:0]  functions_sh;
  logic [7:0]  prescale_sh;
  // Live counter status
  logic [15:0] count_val;
  logic        upnotdown;
  logic        en;
  // Active configuration and status
  logic [15:0] period;
  logic [15:0] compare1;
  logic [15:0] compare2;
  logic [7:0]  functions;
  logic [7:0]  prescale;
  logic        upd_busy;
  logic        upd_done;
  logic        upd_late;
  // FSM state, for checkers and debug (0 = IDLE, 1 = ARMED)
  logic [0:0]  dbg_state;

  modport master (
    output upd_req, upd_mode, upd_abort, clr_late,
    output period_sh, compare1_sh, compare2_sh, functions_sh, prescale_sh,
    output count_val, upnotdown, en,
    input  period, compare1, compare2, functions, prescale,
    input  upd_busy, upd_done, upd_late, dbg_state
  );

  modport slave (
    input  upd_req, upd_mode, upd_abort, clr_late,
    input  period_sh, compare1_sh, compare2_sh, functions_sh, prescale_sh,
    input  count_val, upnotdown, en,
    output period, compare1, compare2, functions, prescale,
    output upd_busy, upd_done, upd_late, dbg_state
  );
endinterface

// File: rtl/pwm_upd_sched.sv
// Glitch-free configuration update scheduler for the PWM timer.
// Shadow values are copied into the active registers in one atomic edge, either
// immediately or at the next counter period boundary (with a timeout fallback).
//
// Handshake: upd_req is a single-cycle strobe sampled on the rising clock edge;
// there is no ready. A commit is reported by upd_done, a one-cycle pulse in the
// cycle the new active values first appear. upd_busy is high for as long as a
// boundary commit is armed.
module pwm_upd_sched #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int TMO_W       = 16
) (
  input  logic clk,
  input  logic rst,
  pwm_upd_sched_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_ZERO = '0;
  localparam bit               TMO_EN   = (TIMEOUT_CYC != 0);

  logic [0:0]       r_state;
  logic [15:0]      r_cnt_q;
  logic [TMO_W-1:0] r_timer;
  logic [15:0]      r_period;
  logic [15:0]      r_compare1;
  logic [15:0]      r_compare2;
  logic [7:0]       r_functions;
  logic [7:0]       r_prescale;
  logic             r_done;
  logic             r_late;

  logic [15:0]      w_start;
  logic             w_boundary;
  logic             w_commit;
  logic             w_set_late;
  logic [0:0]       w_state_nxt;
  logic [TMO_W-1:0] w_timer_nxt;

  // Period boundary: the counter just moved onto its start value. Uses the active
  // period, which cannot change while armed, so detection is stable.
  always_comb begin
    w_start    = bus.upnotdown ? 16'd0 : r_period;
    w_boundary = (bus.count_val != r_cnt_q) && (bus.count_val == w_start);
  end

  // Next-state, commit and timeout decisions
  always_comb begin
    w_commit    = 1'b0;
    w_set_late  = 1'b0;
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    case (r_state)
      ST_IDLE: begin
        // An abort in the same cycle drops the request.
        if (bus.upd_req && !bus.upd_abort) begin
          if (!bus.upd_mode || !bus.en) begin
            w_commit = 1'b1;
          end else begin
            w_state_nxt = ST_ARMED;
            w_timer_nxt = TMO_LOAD;
          end
        end
      end
      ST_ARMED: begin
        if (bus.upd_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_boundary) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (!bus.en) begin
          // Counter stopped: nothing can glitch, commit now.
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (TMO_EN && (r_timer == TMO_ONE)) begin
          w_commit    = 1'b1;
          w_set_late  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (bus.upd_req) begin
          // Re-request restarts the wait; the newest shadows load at commit.
          w_timer_nxt = TMO_LOAD;
        end else if (r_timer != TMO_ZERO) begin
          w_timer_nxt = r_timer - TMO_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, timer and registered counter value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_cnt_q <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_cnt_q <= bus.count_val;
    end
  end

  // Active configuration: all five fields load together on the commit edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period    <= '0;
      r_compare1  <= '0;
      r_compare2  <= '0;
      r_functions <= '0;
      r_prescale  <= '0;
    end else if (w_commit) begin
      r_period    <= bus.period_sh;
      r_compare1  <= bus.compare1_sh;
      r_compare2  <= bus.compare2_sh;
      r_functions <= bus.functions_sh;
      r_prescale  <= bus.prescale_sh;
    end
  end

  // Done pulse and sticky late flag (a new late event beats a clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_late <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_set_late) begin
        r_late <= 1'b1;
      end else if (bus.clr_late) begin
        r_late <= 1'b0;
      end
    end
  end

  assign bus.period    = r_period;
  assign bus.compare1  = r_compare1;
  assign bus.compare2  = r_compare2;
  assign bus.functions = r_functions;
  assign bus.prescale  = r_prescale;
  assign bus.upd_busy  = (r_state == ST_ARMED);
  assign bus.upd_done  = r_done;
  assign bus.upd_late  = r_late;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_pwm_upd_sched.sv
// Bench for pwm_upd_sched: directed counter sequences, expected commits queued
// at stimulus time and checked by an independent monitor on upd_done.
module tb_pwm_upd_sched;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_upd_sched_if pif();

  pwm_upd_sched #(
    .TIMEOUT_CYC(8),
    .TMO_W      (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(pif)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // entry: {commit cycle[32], late, period, cmp1, cmp2, functions, prescale}
  localparam int W = 32 + 1 + 16 + 16 + 16 + 8 + 8;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  logic [15:0] sh_p, sh_c1, sh_c2;
  logic [7:0]  sh_f, sh_ps;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_sh(input logic [15:0] p, input logic [15:0] c1, input logic [15:0] c2,
                        input logic [7:0] f, input logic [7:0] ps);
    sh_p = p; sh_c1 = c1; sh_c2 = c2; sh_f = f; sh_ps = ps;
    pif.period_sh    = p;
    pif.compare1_sh  = c1;
    pif.compare2_sh  = c2;
    pif.functions_sh = f;
    pif.prescale_sh  = ps;
  endtask

  // Expect a commit of the current shadow values at posedge number 'at'
  task automatic push(input int at, input logic lt);
    logic [31:0] at_v;
    at_v = at;
    exp_q.push_back({at_v, lt, sh_p, sh_c1, sh_c2, sh_f, sh_ps});
  endtask

  // Present a counter value for one clock, return at the next falling edge
  task automatic tick(input logic [15:0] c);
    pif.count_val = c;
    @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (pif.upd_done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done_qsize", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_cycle", cyc,           mon_e[96:65]);
          chk("done_late",  pif.upd_late,  mon_e[64]);
          chk("period",     pif.period,    mon_e[63:48]);
          chk("compare1",   pif.compare1,  mon_e[47:32]);
          chk("compare2",   pif.compare2,  mon_e[31:16]);
          chk("functions",  pif.functions, mon_e[15:8]);
          chk("prescale",   pif.prescale,  mon_e[7:0]);
        end
      end else if (exp_q.size() != 0 && int'(exp_q[0][96:65]) < cyc) begin
        chk("missed_done", pif.upd_done, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: sequence did not finish, cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    pif.upd_req = 0; pif.upd_mode = 0; pif.upd_abort = 0; pif.clr_late = 0;
    pif.count_val = 0; pif.upnotdown = 1; pif.en = 0;
    set_sh(0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_period",    pif.period,    0);
    chk("rst_compare1",  pif.compare1,  0);
    chk("rst_compare2",  pif.compare2,  0);
    chk("rst_functions", pif.functions, 0);
    chk("rst_prescale",  pif.prescale,  0);
    chk("rst_busy",      pif.upd_busy,  0);
    chk("rst_done",      pif.upd_done,  0);
    chk("rst_late",      pif.upd_late,  0);
    chk("rst_state",     pif.dbg_state, 0);
    rst = 1'b0;
    tick(0);

    // Immediate commit
    set_sh(100, 30, 0, 0, 0);
    pif.upd_mode = 0; pif.upd_req = 1;
    push(cyc + 1, 0);
    tick(0);
    pif.upd_req = 0;
    chk("imm_busy", pif.upd_busy, 0);
    tick(0); tick(0);

    // Boundary commit, up-count, active period 9
    set_sh(9, 4, 6, 8'h11, 0);
    pif.upd_req = 1;
    push(cyc + 1, 0);
    tick(0);
    pif.upd_req = 0;
    pif.en = 1; pif.upnotdown = 1;
    tick(1); tick(2); tick(3);
    set_sh(19, 5, 7, 8'h22, 0);
    pif.upd_mode = 1; pif.upd_req = 1;
    push(cyc + 6, 0);
    tick(4);
    pif.upd_req = 0;
    tick(5);
    chk("up_busy_armed", pif.upd_busy, 1);
    chk("up_state_armed", pif.dbg_state, 1);
    tick(6); tick(7); tick(8);
    chk("up_busy_before_wrap", pif.upd_busy, 1);
    tick(0);
    chk("up_busy_after_wrap", pif.upd_busy, 0);
    for (int i = 1; i <= 19; i++) tick(16'(i));

    // Boundary commit, down-count: fires on 0 -> period
    pif.upnotdown = 0;
    tick(7); tick(6);
    set_sh(12, 3, 4, 8'h5A, 8'h02);
    pif.upd_req = 1;
    push(cyc + 7, 0);
    tick(5);
    pif.upd_req = 0;
    tick(4); tick(3); tick(2); tick(1); tick(0);
    chk("dn_busy_at_zero", pif.upd_busy, 1);
    tick(19);
    chk("dn_busy_after", pif.upd_busy, 0);

    // Timeout with period 0 (no boundary possible)
    set_sh(0, 0, 0, 0, 0);
    pif.upd_mode = 0; pif.upd_req = 1;
    push(cyc + 1, 0);
    tick(19);
    pif.upd_req = 0;
    tick(0); tick(0);
    set_sh(50, 1, 2, 8'h03, 8'h04);
    pif.upd_mode = 1; pif.upd_req = 1;
    push(cyc + 9, 1);
    tick(0);
    pif.upd_req = 0;
    repeat (7) tick(0);
    chk("tmo_busy_last", pif.upd_busy, 1);
    chk("tmo_late_before", pif.upd_late, 0);
    tick(0);
    chk("tmo_busy_after", pif.upd_busy, 0);
    chk("tmo_late_set", pif.upd_late, 1);
    pif.clr_late = 1;
    tick(0);
    pif.clr_late = 0;
    chk("tmo_late_cleared", pif.upd_late, 0);

    // Abort together with a boundary: no commit
    pif.upnotdown = 1;
    tick(48);
    set_sh(77, 9, 9, 8'h09, 8'h09);
    pif.upd_req = 1;
    tick(49);
    pif.upd_req = 0;
    pif.upd_abort = 1;
    tick(0);
    pif.upd_abort = 0;
    chk("abort_busy", pif.upd_busy, 0);
    tick(1); tick(2);

    // Re-request while armed: newest compare2 wins at the boundary
    set_sh(60, 11, 22, 8'h33, 8'h44);
    pif.upd_req = 1;
    tick(3);
    pif.upd_req = 0;
    tick(4);
    set_sh(60, 11, 7, 8'h33, 8'h44);
    pif.upd_req = 1;
    push(cyc + 3, 0);
    tick(5);
    pif.upd_req = 0;
    tick(6);
    tick(0);
    chk("rereq_busy_after", pif.upd_busy, 0);

    // Abort and request together in IDLE: request dropped
    set_sh(1, 2, 3, 8'h04, 8'h05);
    pif.upd_mode = 0; pif.upd_req = 1; pif.upd_abort = 1;
    tick(0);
    pif.upd_req = 0; pif.upd_abort = 0;
    chk("idle_abort_busy", pif.upd_busy, 0);
    tick(0);

    // Counter disabled while armed: commit at once
    pif.upd_mode = 1; pif.upd_req = 1;
    tick(0);
    pif.upd_req = 0;
    chk("en_busy_armed", pif.upd_busy, 1);
    pif.en = 0;
    push(cyc + 1, 0);
    tick(0);
    chk("en_busy_after", pif.upd_busy, 0);
    pif.en = 1;

    // Reset while armed: everything returns to zero, no later done
    set_sh(33, 34, 35, 8'h36, 8'h37);
    pif.upd_req = 1;
    tick(0);
    pif.upd_req = 0;
    tick(0);
    chk("rst2_busy_before", pif.upd_busy, 1);
    rst = 1'b1;
    #1;
    chk("rst2_period",   pif.period,    0);
    chk("rst2_compare1", pif.compare1,  0);
    chk("rst2_busy",     pif.upd_busy,  0);
    chk("rst2_state",    pif.dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) tick(0);
    chk("rst2_busy_after", pif.upd_busy, 0);
    chk("rst2_period_after", pif.period, 0);

    tick(0); tick(0);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
